// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, constants and fetch-stage types.
package mips_pkg;

  localparam int                 PC_W      = 12;
  localparam int                 INSTR_W   = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
  localparam int                 RAS_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_FLUSH,
    ST_STALL
  } fetch_state_t;

  // Redirect source after priority resolution; CALL is split from JMP for the stack.
  typedef enum logic [2:0] {
    RD_NONE,
    RD_RET,
    RD_BR,
    RD_JMP,
    RD_CALL
  } redir_kind_t;

endpackage

// File: rtl/fetch_ras.sv
// fetch_ras: circular return-address stack; a push when full overwrites the
// oldest entry, and a pop when empty reads as zero.
module fetch_ras
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] data_in,
  output logic [PC_W-1:0] data_out,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_q;    // next slot to write
  logic [PTR_W:0]   count_q;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PTR_W+1)'(RAS_DEPTH));
  assign data_out = empty ? '0 : mem[top_q - PTR_W'(1)];

  // NOTE: stack storage is not reset; emptiness comes from count_q, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[top_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      top_q   <= '0;
      count_q <= '0;
    end else if (push) begin
      top_q <= top_q + PTR_W'(1);
      if (!full) count_q <= count_q + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      top_q   <= top_q - PTR_W'(1);
      count_q <= count_q - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/stage1_fetch.sv
// stage1_fetch: PC register, one-cycle ROM fetch, redirect squash and stall hold.
// Define FETCH_RAS_EN to take RET targets from an internal return-address stack.
module stage1_fetch
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               En_Pipeline,
  output logic [PC_W-1:0]    Imem_Addr,
  input  logic [INSTR_W-1:0] Imem_Data,
  input  logic               BR_flag,
  input  logic [PC_W-1:0]    BR_target,
  input  logic               JMP_flag,
  input  logic               CALL_flag,
  input  logic [PC_W-1:0]    JC_target,
  input  logic               RET_flag,
  input  logic [PC_W-1:0]    RET_addr,
  output logic [INSTR_W-1:0] Instruction,
  output logic [PC_W-1:0]    PC_out,
  output logic               Valid_out
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] hold_q, hold_d;
  redir_kind_t        pend_kind_q, pend_kind_d;
  logic [PC_W-1:0]    pend_tgt_q, pend_tgt_d;
  redir_kind_t        live_kind, eff_kind;
  logic [PC_W-1:0]    live_tgt, eff_tgt;

`ifdef FETCH_RAS_EN
  logic            ras_push, ras_pop;
  logic            ras_empty_unused, ras_full_unused;
  logic [PC_W-1:0] ras_top;
`endif

  assign Imem_Addr = pc_q;
  assign PC_out    = pc_q;

  // NOTE: every always_comb assigns defaults first so no path leaves a variable unassigned (no latches).
  always_comb begin
    live_kind = RD_NONE;
    live_tgt  = '0;
    if (RET_flag) begin
      live_kind = RD_RET;
      live_tgt  = RET_addr;
    end else if (BR_flag) begin
      live_kind = RD_BR;
      live_tgt  = BR_target;
    end else if (CALL_flag || JMP_flag) begin
      live_kind = CALL_flag ? RD_CALL : RD_JMP;
      live_tgt  = JC_target;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    pend_kind_d = pend_kind_q;
    pend_tgt_d  = pend_tgt_q;
    // A live redirect supersedes one latched during a stall.
    eff_kind    = (live_kind != RD_NONE) ? live_kind : pend_kind_q;
    eff_tgt     = (live_kind != RD_NONE) ? live_tgt  : pend_tgt_q;
`ifdef FETCH_RAS_EN
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (eff_kind == RD_RET) eff_tgt = ras_top;
`endif

    if (!En_Pipeline) begin
      if (live_kind != RD_NONE) begin
        pend_kind_d = live_kind;
        pend_tgt_d  = live_tgt;
      end
      if (state_q == ST_RUN) begin
        hold_d  = Imem_Data;
        state_d = ST_STALL;
      end
    end else begin
      pend_kind_d = RD_NONE;
      if (eff_kind != RD_NONE) begin
        pc_d    = eff_tgt;
        state_d = ST_FLUSH;
`ifdef FETCH_RAS_EN
        ras_push = (eff_kind == RD_CALL);
        ras_pop  = (eff_kind == RD_RET);
`endif
      end else begin
        pc_d    = pc_q + PC_W'(1);
        state_d = ST_RUN;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= '0;
      hold_q      <= '0;
      pend_kind_q <= RD_NONE;
      pend_tgt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_q      <= hold_d;
      pend_kind_q <= pend_kind_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

  always_comb begin
    Instruction = NOP_INSTR;
    Valid_out   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        Instruction = Imem_Data;
        Valid_out   = 1'b1;
      end
      ST_STALL: begin
        Instruction = hold_q;
        Valid_out   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef FETCH_RAS_EN
  fetch_ras u_ras (
    .clk      (clk),
    .rst_n    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .data_in  (pc_q + PC_W'(1)),
    .data_out (ras_top),
    .empty    (ras_empty_unused),
    .full     (ras_full_unused)
  );
`endif

endmodule

// File: tb/tb_stage1_fetch.sv
// tb_stage1_fetch: directed bench for stage1_fetch with a synchronous ROM model
// holding word[i] = 32'h00221800 + i.
module tb_stage1_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        En_Pipeline;
  logic [11:0] Imem_Addr;
  logic [31:0] Imem_Data;
  logic        BR_flag, JMP_flag, CALL_flag, RET_flag;
  logic [11:0] BR_target, JC_target, RET_addr;
  logic [31:0] Instruction;
  logic [11:0] PC_out;
  logic        Valid_out;

  int checks = 0;
  int errors = 0;

  logic [44:0] obs;
  logic [44:0] expv;
  assign obs = {Valid_out, PC_out, Instruction};

  always #5 clk = ~clk;

  stage1_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .En_Pipeline (En_Pipeline),
    .Imem_Addr   (Imem_Addr),
    .Imem_Data   (Imem_Data),
    .BR_flag     (BR_flag),
    .BR_target   (BR_target),
    .JMP_flag    (JMP_flag),
    .CALL_flag   (CALL_flag),
    .JC_target   (JC_target),
    .RET_flag    (RET_flag),
    .RET_addr    (RET_addr),
    .Instruction (Instruction),
    .PC_out      (PC_out),
    .Valid_out   (Valid_out)
  );

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    return 32'h00221800 + {20'h0, a};
  endfunction

  always @(posedge clk) Imem_Data <= rom_word(Imem_Addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    BR_flag = 1'b0; JMP_flag = 1'b0; CALL_flag = 1'b0; RET_flag = 1'b0;
  endtask

  // Leaves the bench in the BOOT cycle with PC=0.
  task automatic do_reset();
    clear_flags();
    En_Pipeline = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_flags();
    BR_target = '0; JC_target = '0; RET_addr = '0;
    En_Pipeline = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    expv = {1'b0, 12'h000, 32'h0};
    checks++; if (obs !== expv) begin errors++; $display("FAIL reset_outputs: got %h expected %h", obs, expv); end
    checks++; if (Imem_Addr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h expected %h", Imem_Addr, 12'h000); end
    reset = 1'b1;
    checks++; if (obs !== expv) begin errors++; $display("FAIL boot_bubble: got %h expected %h", obs, expv); end
    tick();
    expv = {1'b1, 12'h001, rom_word(12'h000)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL boot_first_word: got %h expected %h", obs, expv); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      tick();
      expv = {1'b1, 12'(k + 1), rom_word(12'(k))};
      checks++; if (obs !== expv) begin errors++; $display("FAIL seq_word%0d: got %h expected %h", k, obs, expv); end
    end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (5) tick();
    BR_flag = 1'b1; BR_target = 12'h040;
    expv = {1'b1, 12'h005, rom_word(12'h004)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL br_slot_word: got %h expected %h", obs, expv); end
    tick();
    clear_flags();
    expv = {1'b0, 12'h040, 32'h0};
    checks++; if (obs !== expv) begin errors++; $display("FAIL br_bubble: got %h expected %h", obs, expv); end
    tick();
    expv = {1'b1, 12'h041, rom_word(12'h040)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL br_target_word: got %h expected %h", obs, expv); end
    tick();
    expv = {1'b1, 12'h042, rom_word(12'h041)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL br_after_target: got %h expected %h", obs, expv); end
  endtask

  task automatic test_priority();
    logic [11:0] exp_ret;
`ifdef FETCH_RAS_EN
    exp_ret = 12'h000;
`else
    exp_ret = 12'h010;
`endif
    do_reset();
    repeat (3) tick();
    RET_flag = 1'b1; RET_addr = 12'h010;
    BR_flag = 1'b1; BR_target = 12'h020;
    JMP_flag = 1'b1; JC_target = 12'h030;
    tick();
    clear_flags();
    checks++; if (Imem_Addr !== exp_ret) begin errors++; $display("FAIL prio_ret_addr: got %h expected %h", Imem_Addr, exp_ret); end
    tick();
    expv = {1'b1, exp_ret + 12'h001, rom_word(exp_ret)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL prio_ret_word: got %h expected %h", obs, expv); end
    BR_flag = 1'b1; CALL_flag = 1'b1;
    tick();
    clear_flags();
    checks++; if (Imem_Addr !== 12'h020) begin errors++; $display("FAIL prio_br_over_call: got %h expected %h", Imem_Addr, 12'h020); end
    tick();
    JMP_flag = 1'b1;
    tick();
    clear_flags();
    checks++; if (Imem_Addr !== 12'h030) begin errors++; $display("FAIL prio_jmp_alone: got %h expected %h", Imem_Addr, 12'h030); end
  endtask

  task automatic test_flush_override();
    do_reset();
    repeat (2) tick();
    BR_flag = 1'b1; BR_target = 12'h100;
    tick();
    clear_flags();
    JMP_flag = 1'b1; JC_target = 12'h200;
    checks++; if (Imem_Addr !== 12'h100) begin errors++; $display("FAIL flush_first_addr: got %h expected %h", Imem_Addr, 12'h100); end
    tick();
    clear_flags();
    expv = {1'b0, 12'h200, 32'h0};
    checks++; if (obs !== expv) begin errors++; $display("FAIL flush_override: got %h expected %h", obs, expv); end
    tick();
    expv = {1'b1, 12'h201, rom_word(12'h200)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL flush_override_word: got %h expected %h", obs, expv); end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (8) tick();
    En_Pipeline = 1'b0;
    expv = {1'b1, 12'h008, rom_word(12'h007)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL stall_entry: got %h expected %h", obs, expv); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (obs !== expv) begin errors++; $display("FAIL stall_frozen%0d: got %h expected %h", c, obs, expv); end
      checks++; if (Imem_Addr !== 12'h008) begin errors++; $display("FAIL stall_addr%0d: got %h expected %h", c, Imem_Addr, 12'h008); end
    end
    En_Pipeline = 1'b1;
    checks++; if (obs !== expv) begin errors++; $display("FAIL stall_release_hold: got %h expected %h", obs, expv); end
    tick();
    expv = {1'b1, 12'h009, rom_word(12'h008)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL stall_resume_word8: got %h expected %h", obs, expv); end
    tick();
    expv = {1'b1, 12'h00A, rom_word(12'h009)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL stall_resume_word9: got %h expected %h", obs, expv); end
  endtask

  task automatic test_pending();
    do_reset();
    repeat (4) tick();
    En_Pipeline = 1'b0;
    BR_flag = 1'b1; BR_target = 12'h080;
    tick();
    clear_flags();
    expv = {1'b1, 12'h004, rom_word(12'h003)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL pend_held: got %h expected %h", obs, expv); end
    tick();
    checks++; if (Imem_Addr !== 12'h004) begin errors++; $display("FAIL pend_not_applied: got %h expected %h", Imem_Addr, 12'h004); end
    En_Pipeline = 1'b1;
    checks++; if (obs !== expv) begin errors++; $display("FAIL pend_release_hold: got %h expected %h", obs, expv); end
    tick();
    expv = {1'b0, 12'h080, 32'h0};
    checks++; if (obs !== expv) begin errors++; $display("FAIL pend_applied: got %h expected %h", obs, expv); end
    tick();
    expv = {1'b1, 12'h081, rom_word(12'h080)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL pend_target_word: got %h expected %h", obs, expv); end
    tick();
    expv = {1'b1, 12'h082, rom_word(12'h081)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL pend_cleared: got %h expected %h", obs, expv); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    JMP_flag = 1'b1; JC_target = 12'hFFE;
    tick();
    clear_flags();
    tick();
    expv = {1'b1, 12'hFFF, rom_word(12'hFFE)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL wrap_ffe: got %h expected %h", obs, expv); end
    tick();
    checks++; if (Imem_Addr !== 12'h000) begin errors++; $display("FAIL wrap_addr: got %h expected %h", Imem_Addr, 12'h000); end
    expv = {1'b1, 12'h000, rom_word(12'hFFF)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL wrap_fff: got %h expected %h", obs, expv); end
    tick();
    expv = {1'b1, 12'h001, rom_word(12'h000)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL wrap_word0: got %h expected %h", obs, expv); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) tick();
    BR_flag = 1'b1; BR_target = 12'h050;
    tick();
    clear_flags();
    checks++; if (Imem_Addr !== 12'h050) begin errors++; $display("FAIL rflush_pre: got %h expected %h", Imem_Addr, 12'h050); end
    reset = 1'b0;
    tick();
    expv = {1'b0, 12'h000, 32'h0};
    checks++; if (obs !== expv) begin errors++; $display("FAIL rflush_cleared: got %h expected %h", obs, expv); end
    reset = 1'b1;
    tick();
    expv = {1'b1, 12'h001, rom_word(12'h000)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL rflush_restart: got %h expected %h", obs, expv); end
    repeat (2) tick();
    En_Pipeline = 1'b0;
    tick();
    BR_flag = 1'b1; BR_target = 12'h0AA;
    tick();
    clear_flags();
    reset = 1'b0;
    tick();
    expv = {1'b0, 12'h000, 32'h0};
    checks++; if (obs !== expv) begin errors++; $display("FAIL rstall_cleared: got %h expected %h", obs, expv); end
    reset = 1'b1;
    En_Pipeline = 1'b1;
    tick();
    expv = {1'b1, 12'h001, rom_word(12'h000)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL rstall_no_pending: got %h expected %h", obs, expv); end
  endtask

`ifdef FETCH_RAS_EN
  task automatic test_ras();
    logic [11:0] exp_tgt;
    do_reset();
    repeat (3) tick();
    CALL_flag = 1'b1; JC_target = 12'h100;
    tick();
    clear_flags();
    tick();
    RET_flag = 1'b1; RET_addr = 12'hFFF;
    tick();
    clear_flags();
    checks++; if (Imem_Addr !== 12'h004) begin errors++; $display("FAIL ras_ret_addr: got %h expected %h", Imem_Addr, 12'h004); end
    tick();
    expv = {1'b1, 12'h005, rom_word(12'h004)};
    checks++; if (obs !== expv) begin errors++; $display("FAIL ras_ret_word: got %h expected %h", obs, expv); end
    for (int i = 0; i < 9; i++) begin
      CALL_flag = 1'b1; JC_target = 12'(256 + 16 * i);
      tick();
      clear_flags();
      tick();
    end
    for (int j = 0; j < 9; j++) begin
      RET_flag = 1'b1; RET_addr = 12'hFFF;
      tick();
      clear_flags();
      exp_tgt = (j < 8) ? 12'(12'h172 - 16 * j) : 12'h000;
      checks++; if (Imem_Addr !== exp_tgt) begin errors++; $display("FAIL ras_pop%0d: got %h expected %h", j, Imem_Addr, exp_tgt); end
      tick();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_priority();
    test_flush_override();
    test_stall();
    test_pending();
    test_wrap();
    test_reset_mid();
`ifdef FETCH_RAS_EN
    test_ras();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
